// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared FSM states and FIFO entry layout for the UART receive host side.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } rx_state_t;

  localparam int unsigned c_ENTRY_WIDTH     = 11;
  localparam int unsigned c_ERR_PARITY_BIT  = 2;
  localparam int unsigned c_ERR_OVERRUN_BIT = 0;

  // FIFO entry layout: error flags above the data byte
  function automatic logic [c_ENTRY_WIDTH-1:0] pack_entry(input logic [2:0] err,
                                                          input logic [7:0] data);
    return {err, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : uart_rx_fifo
// Brief  : First-word-fall-through receive FIFO; head is zero while empty.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_pop;
  logic               w_push;

  assign o_full  = (r_count == (c_PTR_W+1)'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign w_pop  = i_pop && o_valid;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : uart_rx_controller
// Brief  : Oversampling divider, interrupt/acknowledge handshake and receive FIFO.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int DIVISOR_WIDTH = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int ACK_CYCLES    = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic                        i_enable,
  input  logic [DIVISOR_WIDTH-1:0]    i_divisor,
  output logic                        o_oversampling,
  input  logic                        i_rx_interrupt,
  input  logic [7:0]                  i_rx_data,
  input  logic [2:0]                  i_rx_error,
  output logic                        o_rx_acknowledge,
  input  logic                        i_read_enable,
  output logic                        o_read_valid,
  output logic [7:0]                  o_read_data,
  output logic [2:0]                  o_read_error,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic [7:0]                  o_overflow_count,
  output logic                        o_busy
);

  localparam int c_ACK_W = $clog2(ACK_CYCLES + 1);

  logic [DIVISOR_WIDTH-1:0]   r_div_cnt;
  logic                       r_os;
  logic                       r_int_meta;
  logic                       r_int_sync;
  rx_state_t                  r_state;
  rx_state_t                  w_state_next;
  logic [c_ACK_W-1:0]         r_ack_cnt;
  logic [7:0]                 r_ovf_cnt;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_ack;
  logic                       w_fifo_full;
  logic [c_ENTRY_WIDTH-1:0]   w_head;

  // Divisor is compared live, so a lowered value fires on the very next cycle
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div_cnt <= '0;
      r_os      <= 1'b0;
    end else if (i_enable) begin
      if (r_div_cnt >= i_divisor) begin
        r_div_cnt <= '0;
        r_os      <= ~r_os;
      end else begin
        r_div_cnt <= r_div_cnt + DIVISOR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_int_meta <= 1'b0;
      r_int_sync <= 1'b0;
    end else begin
      r_int_meta <= i_rx_interrupt;
      r_int_sync <= r_int_meta;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_ack_cnt <= '0;
      r_ovf_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ack_cnt <= (r_state == ST_ACK) ? r_ack_cnt + c_ACK_W'(1) : '0;
      if (w_drop && (r_ovf_cnt != 8'hFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_drop       = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_int_sync) begin
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // A full FIFO still accepts the byte when the host pops in this cycle
        w_push       = !w_fifo_full || i_read_enable;
        w_drop       = w_fifo_full && !i_read_enable;
        w_state_next = ST_ACK;
      end
      ST_ACK: begin
        w_ack = 1'b1;
        if (r_ack_cnt == c_ACK_W'(ACK_CYCLES - 1)) begin
          w_state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!r_int_sync) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_ENTRY_WIDTH)
  ) u_fifo (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_push      (w_push),
    .i_push_data (pack_entry(i_rx_error, i_rx_data)),
    .i_pop       (i_read_enable),
    .o_valid     (o_read_valid),
    .o_head      (w_head),
    .o_count     (o_fifo_count),
    .o_full      (w_fifo_full)
  );

  assign o_read_data      = w_head[7:0];
  assign o_read_error     = w_head[10:8];
  assign o_oversampling   = r_os;
  assign o_rx_acknowledge = w_ack;
  assign o_overflow_count = r_ovf_cnt;
  assign o_busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
